// File: rtl/pipe_interlock_ctrl_pkg.sv
// Shared encodings for the decode-stage interlock controller and its MDU sequencer.
package pipe_interlock_ctrl_pkg;

  localparam int REG_ADDR_LEN = 5;

  typedef enum logic [1:0] {
    MDU_NONE = 2'b00,
    MDU_MUL  = 2'b01,
    MDU_DIV  = 2'b10,
    MDU_RSV  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/pipe_interlock_ctrl_mdu_seq.sv
// Multi-cycle MDU sequencer: tracks one multiply/divide from issue to the HI/LO write.
module pipe_interlock_ctrl_mdu_seq
  import pipe_interlock_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic clock,
  input  logic resetn,
  input  logic start,
  input  logic is_div,
  input  logic div_zero,
  output logic busy,
  output logic hilo_we
);

  if (MUL_LAT < 2 || DIV_LAT < 2 ||
      (MUL_LAT - 1) >= (1 << CNT_W) || (DIV_LAT - 1) >= (1 << CNT_W)) begin : g_param_check
    $error("pipe_interlock_ctrl_mdu_seq: latency parameters out of range for CNT_W");
  end

  // BUSY spans LAT-1 cycles, so the counter is loaded with LAT-2 and DONE adds the last one.
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 2);

  mdu_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             nodiv, nodiv_next;
  logic             hilo_we_next;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      nodiv   <= 1'b0;
      hilo_we <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      nodiv   <= nodiv_next;
      hilo_we <= hilo_we_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    nodiv_next   = nodiv;
    hilo_we_next = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = BUSY;
          cnt_next   = is_div ? DIV_CNT : MUL_CNT;
          nodiv_next = is_div & div_zero;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_next   = DONE;
          // A divide by zero leaves HI/LO untouched.
          hilo_we_next = ~nodiv;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/pipe_interlock_ctrl.sv
// Decode-stage interlock: load-use and MDU structural hazards, stall steering and stall accounting.
module pipe_interlock_ctrl
  import pipe_interlock_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [REG_ADDR_LEN-1:0] rs,
  input  logic [REG_ADDR_LEN-1:0] rt,
  input  logic                    use_rs,
  input  logic                    use_rt,
  input  logic [REG_ADDR_LEN-1:0] ern,
  input  logic                    ewreg,
  input  logic                    em2reg,
  input  logic [1:0]              mdu_op,
  input  logic                    mfhilo,
  input  logic                    div_zero,
  output logic                    wpcir,
  output logic                    dbubble,
  output logic                    mdu_start,
  output logic                    mdu_busy,
  output logic                    hilo_we,
  output logic                    lu_stall,
  output logic                    mdu_stall,
  output logic [31:0]             stall_cycles
);

  logic mdu_req;
  logic stall;

  // The reserved encoding behaves exactly like "no MDU op".
  assign mdu_req = (mdu_op == MDU_MUL) || (mdu_op == MDU_DIV);

  assign lu_stall  = ewreg & em2reg & (ern != '0) &
                     ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
  assign mdu_stall = mdu_busy & (mfhilo | mdu_req);
  assign stall     = lu_stall | mdu_stall;

  assign wpcir     = ~stall;
  assign dbubble   = stall;
  assign mdu_start = mdu_req & ~stall & ~mdu_busy;

  pipe_interlock_ctrl_mdu_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_seq (
    .clock    (clock),
    .resetn   (resetn),
    .start    (mdu_start),
    .is_div   (mdu_op == MDU_DIV),
    .div_zero (div_zero),
    .busy     (mdu_busy),
    .hilo_we  (hilo_we)
  );

  // Saturating so long-running performance counters never wrap back to a small value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_interlock_ctrl.sv
// Scoreboard bench for pipe_interlock_ctrl: directed cycles push expectations, a negedge monitor checks them.
module tb_pipe_interlock_ctrl;

  typedef struct {
    string       name;
    logic        wpcir;
    logic        dbubble;
    logic        mdu_start;
    logic        mdu_busy;
    logic        hilo_we;
    logic        lu_stall;
    logic        mdu_stall;
    logic [31:0] stall_cycles;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic [4:0]  rs, rt, ern;
  logic        use_rs, use_rt, ewreg, em2reg, mfhilo, div_zero;
  logic [1:0]  mdu_op;
  logic        wpcir, dbubble, mdu_start, mdu_busy, hilo_we, lu_stall, mdu_stall;
  logic [31:0] stall_cycles;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_sc = 0;

  pipe_interlock_ctrl #(.MUL_LAT(4), .DIV_LAT(33), .CNT_W(6)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .rs           (rs),
    .rt           (rt),
    .use_rs       (use_rs),
    .use_rt       (use_rt),
    .ern          (ern),
    .ewreg        (ewreg),
    .em2reg       (em2reg),
    .mdu_op       (mdu_op),
    .mfhilo       (mfhilo),
    .div_zero     (div_zero),
    .wpcir        (wpcir),
    .dbubble      (dbubble),
    .mdu_start    (mdu_start),
    .mdu_busy     (mdu_busy),
    .hilo_we      (hilo_we),
    .lu_stall     (lu_stall),
    .mdu_stall    (mdu_stall),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h at %0t", name, field, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a full output vector every cycle; sample mid-cycle.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_output(e.name, "wpcir",        32'(wpcir),     32'(e.wpcir));
      check_output(e.name, "dbubble",      32'(dbubble),   32'(e.dbubble));
      check_output(e.name, "mdu_start",    32'(mdu_start), 32'(e.mdu_start));
      check_output(e.name, "mdu_busy",     32'(mdu_busy),  32'(e.mdu_busy));
      check_output(e.name, "hilo_we",      32'(hilo_we),   32'(e.hilo_we));
      check_output(e.name, "lu_stall",     32'(lu_stall),  32'(e.lu_stall));
      check_output(e.name, "mdu_stall",    32'(mdu_stall), 32'(e.mdu_stall));
      check_output(e.name, "stall_cycles", stall_cycles,   e.stall_cycles);
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    rs = 5'd0; rt = 5'd0; ern = 5'd0;
    use_rs = 1'b0; use_rt = 1'b0; ewreg = 1'b0; em2reg = 1'b0;
    mfhilo = 1'b0; div_zero = 1'b0; mdu_op = 2'b00;
  endtask

  // Push the hand-derived response for the cycle whose inputs were just driven.
  task automatic apply_stimulus(input string name, input logic wp, input logic st,
                                input logic bz, input logic hw, input logic lu, input logic ms);
    exp_t e;
    e.name = name; e.wpcir = wp; e.dbubble = ~wp; e.mdu_start = st; e.mdu_busy = bz;
    e.hilo_we = hw; e.lu_stall = lu; e.mdu_stall = ms; e.stall_cycles = exp_sc;
    sb.push_back(e);
    if (!wp && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 1;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();

    next_cycle(); apply_stimulus("reset", 1, 0, 0, 0, 0, 0);
    next_cycle(); resetn = 1'b1; apply_stimulus("post_reset", 1, 0, 0, 0, 0, 0);

    // Load-use detection and its qualifiers.
    next_cycle(); ewreg = 1; em2reg = 1; ern = 5; rs = 5; use_rs = 1;
    apply_stimulus("lu_rs", 0, 0, 0, 0, 1, 0);
    next_cycle(); ern = 0; rs = 0;
    apply_stimulus("lu_r0", 1, 0, 0, 0, 0, 0);
    next_cycle(); ern = 5; rs = 5; use_rs = 0;
    apply_stimulus("lu_no_use", 1, 0, 0, 0, 0, 0);
    next_cycle(); rt = 5; use_rt = 1;
    apply_stimulus("lu_rt", 0, 0, 0, 0, 1, 0);
    next_cycle(); em2reg = 0;
    apply_stimulus("lu_not_load", 1, 0, 0, 0, 0, 0);
    next_cycle(); idle_inputs(); mdu_op = 2'b11;
    apply_stimulus("rsv_idle", 1, 0, 0, 0, 0, 0);

    // Multiply: issue at cycle 0, busy 1-4, hilo_we at 4, idle at 5.
    next_cycle(); mdu_op = 2'b01; apply_stimulus("mul_c0", 1, 1, 0, 0, 0, 0);
    next_cycle(); mdu_op = 2'b00; apply_stimulus("mul_c1", 1, 0, 1, 0, 0, 0);
    next_cycle(); mdu_op = 2'b11; apply_stimulus("mul_c2_rsv", 1, 0, 1, 0, 0, 0);
    next_cycle(); mdu_op = 2'b00; apply_stimulus("mul_c3", 1, 0, 1, 0, 0, 0);
    next_cycle(); apply_stimulus("mul_c4", 1, 0, 1, 1, 0, 0);
    next_cycle(); apply_stimulus("mul_c5", 1, 0, 0, 0, 0, 0);

    // Divide with mfhilo waiting from cycle 1: stalled 1-33, proceeds at 34.
    next_cycle(); mdu_op = 2'b10; apply_stimulus("div_c0", 1, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 33; c++) begin
      next_cycle(); mdu_op = 2'b00; mfhilo = 1;
      apply_stimulus($sformatf("div_mf_c%0d", c), 0, 0, 1, (c == 33), 0, 1);
    end
    next_cycle(); apply_stimulus("div_mf_c34", 1, 0, 0, 0, 0, 0);
    next_cycle(); idle_inputs(); apply_stimulus("div_mf_after", 1, 0, 0, 0, 0, 0);

    // Divide by zero: full busy window, no HI/LO write.
    next_cycle(); mdu_op = 2'b10; div_zero = 1; apply_stimulus("dz_c0", 1, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 33; c++) begin
      next_cycle(); mdu_op = 2'b00; div_zero = 0;
      apply_stimulus($sformatf("dz_c%0d", c), 1, 0, 1, 0, 0, 0);
    end
    next_cycle(); apply_stimulus("dz_c34", 1, 0, 0, 0, 0, 0);

    // Load-use overlapping a back-to-back multiply.
    next_cycle(); mdu_op = 2'b01; apply_stimulus("sim_c0", 1, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle(); ewreg = 1; em2reg = 1; ern = 7; rs = 7; use_rs = 1; mdu_op = 2'b01;
      apply_stimulus($sformatf("sim_c%0d", c), 0, 0, 1, (c == 4), 1, 1);
    end
    next_cycle(); apply_stimulus("sim_c5_lu_only", 0, 0, 0, 0, 1, 0);
    next_cycle(); ewreg = 0; apply_stimulus("sim_c6_issue", 1, 1, 0, 0, 0, 0);
    for (int c = 7; c <= 11; c++) begin
      next_cycle(); idle_inputs();
      apply_stimulus($sformatf("sim_c%0d", c), 1, 0, (c <= 10), (c == 10), 0, 0);
    end

    // Reset in the middle of a divide, after stalls have been counted.
    next_cycle(); mdu_op = 2'b10; apply_stimulus("rst_c0", 1, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 9; c++) begin
      next_cycle(); mdu_op = 2'b00; mfhilo = 1;
      apply_stimulus($sformatf("rst_c%0d", c), 0, 0, 1, 0, 0, 1);
    end
    next_cycle(); resetn = 0; idle_inputs(); exp_sc = 0;
    apply_stimulus("rst_c10", 1, 0, 0, 0, 0, 0);
    next_cycle(); apply_stimulus("rst_c11", 1, 0, 0, 0, 0, 0);
    next_cycle(); resetn = 1; apply_stimulus("rst_release", 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 30; c++) begin
      next_cycle(); apply_stimulus($sformatf("rst_quiet%0d", c), 1, 0, 0, 0, 0, 0);
    end

    // Let the monitor drain the scoreboard within a bounded window.
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clock);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
